// File: rtl/sum_checker_pkg.sv
// Shared types and constants for the adder-datapath result checker.
package sum_checker_pkg;

  // Checker state, also exported on the debug port of the top.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FAIL = 2'd2
  } state_t;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating increment used by the pass/error counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with combinational head data. Push while full is accepted
// only when a pop happens in the same cycle; pop while empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally (power-of-two depth); count resolves full/empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sum_checker.sv
// In-order result checker for the 16-bit adder datapath: records A+B for each
// operand pair and compares every returned result against the oldest one.
//
// Handshake: op_valid=1 at a clk edge offers one operand pair; res_valid=1 at
// a clk edge offers one result. There is no back-pressure: the checker always
// samples both, and reports overflow/underflow when it cannot honour them.
module sum_checker
  import sum_checker_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 8,
  parameter int TIMEOUT     = 64,
  parameter int STOP_ON_ERR = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             op_valid,
  input  logic [WIDTH-1:0] C,
  input  logic             res_valid,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err,
  output logic [WIDTH-1:0] last_exp,
  output logic [WIDTH-1:0] last_got,
  output logic             fail,
  output logic             ovf,
  output logic             unf,
  output logic             tmo,
  output logic             busy,
  output state_t           state
);

  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT > 0) ? TMO_W'(TIMEOUT - 1) : '0;
  localparam logic [TMO_W-1:0] TMO_END  = (TIMEOUT > 0) ? TMO_W'(TIMEOUT) : '0;

  logic             active;
  logic             empty;
  logic             full;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] op_sum;
  logic [WIDTH-1:0] cmp_exp;
  logic             bypass;
  logic             do_pop;
  logic             do_push;
  logic             do_cmp;
  logic             mismatch;
  logic             unf_ev;
  logic             ovf_ev;
  logic             tmo_ev;
  logic             any_err;
  logic             next_empty;
  logic [TMO_W-1:0] timer;

  // In FAIL everything freezes, so all events are qualified by active.
  assign active   = (state != ST_FAIL);
  assign op_sum   = A + B;
  assign bypass   = active && op_valid && res_valid && empty;
  assign do_pop   = active && res_valid && !empty;
  assign do_cmp   = do_pop || bypass;
  assign cmp_exp  = empty ? op_sum : head;
  assign mismatch = do_cmp && (C != cmp_exp);
  assign unf_ev   = active && res_valid && !op_valid && empty;
  assign ovf_ev   = active && op_valid && !res_valid && full;
  assign do_push  = active && op_valid && !bypass && (!full || res_valid);
  assign tmo_ev   = (TIMEOUT > 0) && active && !empty && !do_pop && (timer == TMO_LAST);
  assign any_err  = mismatch || unf_ev || ovf_ev || tmo_ev;
  assign busy     = !empty;

  assign next_empty = (empty && !do_push) ||
                      ((count == CW'(1)) && do_pop && !do_push);

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (do_push),
    .pop   (do_pop),
    .wdata (op_sum),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Age of the oldest entry; parks at TIMEOUT so the flag fires only once.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
    end else if (active) begin
      if (empty || do_pop) begin
        timer <= '0;
      end else if ((TIMEOUT > 0) && (timer != TMO_END)) begin
        timer <= timer + TMO_W'(1);
      end
    end
  end

  // FSM with registered counters, pulse, capture registers and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      pass_cnt <= '0;
      err_cnt  <= '0;
      err      <= 1'b0;
      last_exp <= '0;
      last_got <= '0;
      fail     <= 1'b0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
      tmo      <= 1'b0;
    end else begin
      err <= 1'b0;
      if (active) begin
        if (do_cmp && !mismatch) pass_cnt <= sat_inc(pass_cnt);
        if (mismatch) begin
          err_cnt  <= sat_inc(err_cnt);
          err      <= 1'b1;
          last_exp <= cmp_exp;
          last_got <= C;
        end
        if (unf_ev)  unf  <= 1'b1;
        if (ovf_ev)  ovf  <= 1'b1;
        if (tmo_ev)  tmo  <= 1'b1;
        if (any_err) fail <= 1'b1;
        if (any_err && (STOP_ON_ERR != 0)) begin
          state <= ST_FAIL;
        end else begin
          state <= next_empty ? ST_IDLE : ST_RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_sum_checker.sv
// Bench for sum_checker: three instances share one stimulus stream
// (defaults, TIMEOUT=4, STOP_ON_ERR=0). The default instance is tracked
// cycle by cycle against a reference model built around an expected queue.
module tb_sum_checker;
  import sum_checker_pkg::*;

  localparam int W = 16;

  typedef struct packed {
    logic [15:0] pass_cnt;
    logic [15:0] err_cnt;
    logic        err;
    logic [15:0] last_exp;
    logic [15:0] last_got;
    logic        fail;
    logic        ovf;
    logic        unf;
    logic        tmo;
    logic        busy;
    state_t      state;
  } obs_t;

  // clock / reset / shared stimulus
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] a = '0, b = '0, c = '0;
  logic         op_valid = 1'b0, res_valid = 1'b0;

  always #5 clk = ~clk;

  logic [15:0] mn_pass, mn_errc, mn_lexp, mn_lgot;
  logic        mn_err, mn_fail, mn_ovf, mn_unf, mn_tmo, mn_busy;
  state_t      mn_state;
  logic [15:0] t4_pass, t4_errc, t4_lexp, t4_lgot;
  logic        t4_err, t4_fail, t4_ovf, t4_unf, t4_tmo, t4_busy;
  state_t      t4_state;
  logic [15:0] ns_pass, ns_errc, ns_lexp, ns_lgot;
  logic        ns_err, ns_fail, ns_ovf, ns_unf, ns_tmo, ns_busy;
  state_t      ns_state;

  obs_t o_main, o_t4, o_ns;
  assign o_main = {mn_pass, mn_errc, mn_err, mn_lexp, mn_lgot, mn_fail, mn_ovf, mn_unf, mn_tmo, mn_busy, mn_state};
  assign o_t4   = {t4_pass, t4_errc, t4_err, t4_lexp, t4_lgot, t4_fail, t4_ovf, t4_unf, t4_tmo, t4_busy, t4_state};
  assign o_ns   = {ns_pass, ns_errc, ns_err, ns_lexp, ns_lgot, ns_fail, ns_ovf, ns_unf, ns_tmo, ns_busy, ns_state};

  sum_checker u_main (
    .clk(clk), .rst(rst), .A(a), .B(b), .op_valid(op_valid), .C(c), .res_valid(res_valid),
    .pass_cnt(mn_pass), .err_cnt(mn_errc), .err(mn_err), .last_exp(mn_lexp), .last_got(mn_lgot),
    .fail(mn_fail), .ovf(mn_ovf), .unf(mn_unf), .tmo(mn_tmo), .busy(mn_busy), .state(mn_state)
  );

  sum_checker #(.TIMEOUT(4)) u_t4 (
    .clk(clk), .rst(rst), .A(a), .B(b), .op_valid(op_valid), .C(c), .res_valid(res_valid),
    .pass_cnt(t4_pass), .err_cnt(t4_errc), .err(t4_err), .last_exp(t4_lexp), .last_got(t4_lgot),
    .fail(t4_fail), .ovf(t4_ovf), .unf(t4_unf), .tmo(t4_tmo), .busy(t4_busy), .state(t4_state)
  );

  sum_checker #(.STOP_ON_ERR(0)) u_ns (
    .clk(clk), .rst(rst), .A(a), .B(b), .op_valid(op_valid), .C(c), .res_valid(res_valid),
    .pass_cnt(ns_pass), .err_cnt(ns_errc), .err(ns_err), .last_exp(ns_lexp), .last_got(ns_lgot),
    .fail(ns_fail), .ovf(ns_ovf), .unf(ns_unf), .tmo(ns_tmo), .busy(ns_busy), .state(ns_state)
  );

  // scoreboard: expected sums and the expected output image of u_main
  logic [W-1:0] exp_q[$];
  obs_t         m;
  int           m_tmr;
  int           n_checks = 0;
  int           n_pass   = 0;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_main();
    check("pass_cnt", o_main.pass_cnt, m.pass_cnt);
    check("err_cnt",  o_main.err_cnt,  m.err_cnt);
    check("err",      o_main.err,      m.err);
    check("last_exp", o_main.last_exp, m.last_exp);
    check("last_got", o_main.last_got, m.last_got);
    check("fail",     o_main.fail,     m.fail);
    check("ovf",      o_main.ovf,      m.ovf);
    check("unf",      o_main.unf,      m.unf);
    check("tmo",      o_main.tmo,      m.tmo);
    check("busy",     o_main.busy,     m.busy);
    check("state",    o_main.state,    m.state);
  endtask

  // Reference behaviour for the default instance (TIMEOUT=64, stop on error).
  task automatic model_step(input logic ov, input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic rv, input logic [W-1:0] cv);
    logic         emp, ful, ev, popped;
    logic [W-1:0] e, s;
    m.err = 1'b0;
    if (m.state == ST_FAIL) return;
    s      = av + bv;
    emp    = (exp_q.size() == 0);
    ful    = (exp_q.size() == 8);
    ev     = 1'b0;
    popped = 1'b0;
    if (rv) begin
      if (emp && !ov) begin
        m.unf = 1'b1;
        ev    = 1'b1;
      end else begin
        if (emp) e = s;
        else begin
          e      = exp_q.pop_front();
          popped = 1'b1;
        end
        if (cv == e) m.pass_cnt = m.pass_cnt + 16'd1;
        else begin
          m.err_cnt  = m.err_cnt + 16'd1;
          m.err      = 1'b1;
          m.last_exp = e;
          m.last_got = cv;
          ev         = 1'b1;
        end
      end
    end
    if (ov && !(rv && emp)) begin
      if (ful && !rv) begin
        m.ovf = 1'b1;
        ev    = 1'b1;
      end else exp_q.push_back(s);
    end
    if (emp || popped) m_tmr = 0;
    else if (m_tmr < 64) begin
      m_tmr++;
      if (m_tmr == 64) begin
        m.tmo = 1'b1;
        ev    = 1'b1;
      end
    end
    if (ev) begin
      m.fail  = 1'b1;
      m.state = ST_FAIL;
    end else m.state = (exp_q.size() == 0) ? ST_IDLE : ST_RUN;
    m.busy = (exp_q.size() != 0);
  endtask

  // driver: one clock of stimulus, then model update and output check
  task automatic cycle(input logic ov, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic rv, input logic [W-1:0] cv);
    op_valid = ov; a = av; b = bv; res_valid = rv; c = cv;
    @(posedge clk); #1;
    model_step(ov, av, bv, rv, cv);
    check_main();
    op_valid = 1'b0; res_valid = 1'b0;
  endtask

  task automatic idle();
    cycle(1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1; op_valid = 1'b0; res_valid = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    m     = '0;
    m_tmr = 0;
    check_main();
    check("rst_t4", o_t4, '0);
    check("rst_ns", o_ns, '0);
    rst = 1'b0;
  endtask

  initial begin
    logic         ov, rv;
    logic [W-1:0] av, bv, cv;

    do_reset();

    // basic push then result two cycles later
    cycle(1'b1, 16'd1, 16'd2, 1'b0, '0);
    idle();
    cycle(1'b0, '0, '0, 1'b1, 16'd3);
    check("s1_pass", o_main.pass_cnt, 16'd1);
    check("s1_busy", o_main.busy, 1'b0);
    check("s1_state", o_main.state, ST_IDLE);

    // wrap-around sum, then a wrong result
    do_reset();
    cycle(1'b1, 16'hFFFF, 16'h0002, 1'b0, '0);
    cycle(1'b0, '0, '0, 1'b1, 16'h0001);
    check("s2_wrap_pass", o_main.pass_cnt, 16'd1);
    cycle(1'b1, 16'hFFFF, 16'h0002, 1'b0, '0);
    cycle(1'b0, '0, '0, 1'b1, 16'h0000);
    check("s2_err", o_main.err, 1'b1);
    check("s2_err_cnt", o_main.err_cnt, 16'd1);
    check("s2_last_exp", o_main.last_exp, 16'h0001);
    check("s2_last_got", o_main.last_got, 16'h0000);
    check("s2_state", o_main.state, ST_FAIL);
    idle();
    check("s2_err_pulse", o_main.err, 1'b0);

    // overflow on a lone ninth push
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, W'(i), W'(i), 1'b0, '0);
    cycle(1'b1, 16'd8, 16'd8, 1'b0, '0);
    check("s3_ovf", o_main.ovf, 1'b1);

    // ninth push with a same-cycle pop is accepted; drain all nine
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, W'(i), W'(i), 1'b0, '0);
    cycle(1'b1, 16'd8, 16'd8, 1'b1, 16'd0);
    check("s3_no_ovf", o_main.ovf, 1'b0);
    for (int i = 1; i < 9; i++) cycle(1'b0, '0, '0, 1'b1, W'(2 * i));
    check("s3_pass9", o_main.pass_cnt, 16'd9);
    check("s3_drained", o_main.busy, 1'b0);

    // bypass on empty FIFO, then underflow
    do_reset();
    cycle(1'b1, 16'd5, 16'd7, 1'b1, 16'd12);
    check("s4_bypass_pass", o_main.pass_cnt, 16'd1);
    check("s4_bypass_busy", o_main.busy, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 16'd9);
    check("s4_unf", o_main.unf, 1'b1);
    check("s4_unf_pass", o_main.pass_cnt, 16'd1);
    check("s4_unf_errc", o_main.err_cnt, 16'd0);

    // timeout on the TIMEOUT=4 instance
    do_reset();
    cycle(1'b1, 16'd1, 16'd1, 1'b0, '0);
    for (int j = 1; j <= 4; j++) begin
      idle();
      check($sformatf("s5_tmo_%0d", j), o_t4.tmo, (j == 4) ? 1'b1 : 1'b0);
    end
    check("s5_tmo_fail", o_t4.fail, 1'b1);
    check("s5_tmo_busy", o_t4.busy, 1'b1);

    // reset in the middle of a wait clears everything
    do_reset();
    cycle(1'b1, 16'd3, 16'd4, 1'b0, '0);
    idle();
    idle();
    do_reset();

    // no-stop instance: wrong / right / wrong
    cycle(1'b1, 16'd1, 16'd1, 1'b0, '0);
    cycle(1'b1, 16'd2, 16'd2, 1'b0, '0);
    cycle(1'b1, 16'd3, 16'd3, 1'b0, '0);
    cycle(1'b0, '0, '0, 1'b1, 16'd0);
    cycle(1'b0, '0, '0, 1'b1, 16'd4);
    cycle(1'b0, '0, '0, 1'b1, 16'd0);
    check("s6_errc", o_ns.err_cnt, 16'd2);
    check("s6_pass", o_ns.pass_cnt, 16'd1);
    check("s6_state", o_ns.state, ST_IDLE);
    check("s6_fail", o_ns.fail, 1'b1);
    check("s6_last_exp", o_ns.last_exp, 16'd6);
    check("s6_last_got", o_ns.last_got, 16'd0);

    // random traffic against the scoreboard
    do_reset();
    for (int i = 0; i < 60; i++) begin
      ov = 1'($urandom_range(0, 1));
      av = W'($urandom);
      bv = W'($urandom);
      if (exp_q.size() != 0) begin
        rv = 1'($urandom_range(0, 1));
        cv = exp_q[0];
      end else begin
        rv = ov && 1'($urandom_range(0, 1));
        cv = av + bv;
      end
      if (!rv && exp_q.size() == 8) ov = 1'b0;
      if ($urandom_range(0, 39) == 0) cv = cv ^ 16'h0010;
      cycle(ov, av, bv, rv, cv);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
